// File: rtl/uart_tx_fifo_ctrl.sv
// UART TX buffer: byte FIFO plus launch controller.
// Pops one byte per idle transmitter, tracks tx_done, flags errors.
module uart_tx_fifo_ctrl #(
  parameter int DATA_BITS      = 8,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       wr_en,
  input  logic [DATA_BITS-1:0]       wr_data,
  input  logic                       flush,
  input  logic                       enable,
  input  logic                       err_clr,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       tx_en,
  output logic [DATA_BITS-1:0]       tx_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       tx_err,
  output logic                       ctrl_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    WAIT_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [TW-1:0]        tcnt;
  logic [CW-1:0]        cnt_nxt;
  logic                 push;
  logic                 launch;
  logic                 tmo;
  logic                 ovf_set;

  // Writes are refused when full or flushing; full-write is an overflow.
  assign push    = wr_en & ~full & ~flush;
  assign ovf_set = wr_en & full & ~flush;

  // Launch decision and frame-completion / timeout tracking.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && !empty && !tx_busy && !flush) begin
          launch    = 1'b1;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_nxt = IDLE;
        end else if (tcnt == TMO_LAST) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next occupancy from push/pop, with flush taking priority.
  always_comb begin
    cnt_nxt = count;
    if (flush) begin
      cnt_nxt = '0;
    end else if (push && !launch) begin
      cnt_nxt = count + CW'(1);
    end else if (launch && !push) begin
      cnt_nxt = count - CW'(1);
    end
  end

  // FIFO storage; no reset needed, validity comes from count.
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Controller state, pointers, occupancy flags and launch outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      tx_en     <= 1'b0;
      tx_data   <= '0;
      tcnt      <= '0;
      ctrl_busy <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= cnt_nxt;
      full      <= (cnt_nxt == CW'(DEPTH));
      empty     <= (cnt_nxt == '0);
      tx_en     <= launch;
      ctrl_busy <= (state_nxt == WAIT_DONE);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (launch) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
      if (launch) begin
        tx_data <= mem[rd_ptr];
        tcnt    <= '0;
      end else if (state == WAIT_DONE) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  // Sticky error flags; a same-cycle set beats err_clr.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      overflow <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      overflow <= ovf_set | (overflow & ~err_clr);
      tx_err   <= tmo | (tx_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Randomized bench for uart_tx_fifo_ctrl.
// Queue-based reference model plus a stub transmitter.
module tb_uart_tx_fifo_ctrl;

  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          wr_en;
  logic [DB-1:0] wr_data;
  logic          flush;
  logic          enable;
  logic          err_clr;
  logic          tx_busy;
  logic          tx_done;
  logic          tx_en;
  logic [DB-1:0] tx_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          tx_err;
  logic          ctrl_busy;

  uart_tx_fifo_ctrl #(
    .DATA_BITS(DB),
    .DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .flush(flush),
    .enable(enable),
    .err_clr(err_clr),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_en(tx_en),
    .tx_data(tx_data),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .tx_err(tx_err),
    .ctrl_busy(ctrl_busy)
  );

  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [DB-1:0] q[$];
  bit            m_busy;
  int            m_launch_n;
  bit            m_en;
  logic [DB-1:0] m_data;
  bit            m_ovf;
  bit            m_err;
  int            n;
  bit            m_launch;
  bit            m_tmo;

  // stub transmitter
  bit s_active;
  bit s_hang;
  int s_left;

  int p_wr, p_en, p_flush, p_hang;

  task automatic model_reset();
    q.delete();
    m_busy   = 0;
    m_en     = 0;
    m_data   = '0;
    m_ovf    = 0;
    m_err    = 0;
    s_active = 0;
    s_hang   = 0;
    s_left   = 0;
  endtask

  task automatic check_reset_vals();
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_err", tx_err, 0);
    check("rst_ctrl_busy", ctrl_busy, 0);
  endtask

  task automatic check_outputs();
    check("tx_en", tx_en, m_en);
    check("tx_data", tx_data, m_data);
    check("count", count, q.size());
    check("full", full, q.size() == DEPTH);
    check("empty", empty, q.size() == 0);
    check("overflow", overflow, m_ovf);
    check("tx_err", tx_err, m_err);
    check("ctrl_busy", ctrl_busy, m_busy);
  endtask

  // One clock edge of the abstract behaviour, using pre-edge inputs.
  task automatic model_step();
    bit fulln;
    fulln    = (q.size() == DEPTH);
    m_launch = !m_busy && enable && q.size() != 0 && !tx_busy && !flush;
    m_tmo    = m_busy && !tx_done && (n - m_launch_n == TO);
    m_ovf    = (wr_en && fulln && !flush) || (m_ovf && !err_clr);
    m_err    = m_tmo || (m_err && !err_clr);
    m_en     = m_launch;
    if (flush) begin
      q.delete();
    end else begin
      if (m_launch) m_data = q.pop_front();
      if (wr_en && !fulln) q.push_back(wr_data);
    end
    if (m_launch) begin
      m_busy     = 1;
      m_launch_n = n;
    end else if (m_busy && (tx_done || m_tmo)) begin
      m_busy = 0;
    end
  endtask

  task automatic drive();
    wr_en   = ($urandom_range(0, 99) < p_wr);
    wr_data = DB'($urandom);
    flush   = ($urandom_range(0, 99) < p_flush);
    enable  = ($urandom_range(0, 99) < p_en);
    err_clr = ($urandom_range(0, 99) < 5);
    tx_done = s_active && !s_hang && (s_left == 0);
    tx_busy = s_active || ($urandom_range(0, 9) == 0);
  endtask

  task automatic cycle();
    @(negedge PCLK);
    drive();
    @(posedge PCLK);
    n++;
    model_step();
    #1;
    check_outputs();
    if (s_active && (tx_done || m_tmo)) s_active = 0;
    else if (s_active && s_left > 0) s_left--;
    if (m_launch) begin
      s_active = 1;
      s_left   = $urandom_range(0, 6);
      s_hang   = ($urandom_range(0, 99) < p_hang);
    end
  endtask

  initial begin
    bit found;
    PRESETn = 1'b0;
    wr_en   = 0;
    wr_data = '0;
    flush   = 0;
    enable  = 0;
    err_clr = 0;
    tx_busy = 0;
    tx_done = 0;
    n       = 0;
    model_reset();
    #12;
    check_reset_vals();
    @(negedge PCLK);
    PRESETn = 1'b1;

    for (int ph = 0; ph < 4; ph++) begin
      unique case (ph)
        0: begin p_wr = 60; p_en = 0;   p_flush = 0; p_hang = 0;  end
        1: begin p_wr = 30; p_en = 80;  p_flush = 2; p_hang = 10; end
        2: begin p_wr = 70; p_en = 100; p_flush = 5; p_hang = 0;  end
        default: begin p_wr = 40; p_en = 90; p_flush = 1; p_hang = 50; end
      endcase
      for (int i = 0; i < 400; i++) cycle();
    end

    // reach a frame in flight with bytes still queued
    p_wr = 80; p_en = 100; p_flush = 0; p_hang = 0;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      cycle();
      if (m_busy && q.size() >= 1) found = 1;
    end
    check("reset_setup", found, 1);

    @(negedge PCLK);
    wr_en  = 0;
    flush  = 0;
    enable = 1;
    #2;
    PRESETn = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    p_wr = 0; p_en = 100; p_flush = 0;
    for (int i = 0; i < 20; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
- TX-side buffer and launch controller. It sits directly upstream of the UART transmitter, between the APB register interface and the transmitter.
- Absorbs byte writes into a synchronous FIFO. Pops one byte at a time and issues a single-cycle tx_en pulse with stable tx_data whenever the transmitter is idle.
- Tracks frame completion via tx_done and flags overflow and transmitter-timeout errors for the status register.

Parameters:
- DATA_BITS, 8, width of each FIFO entry and of tx_data.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 131072, max PCLK cycles from launch to tx_done before the controller aborts the wait; must exceed one full frame.

Ports:
- PCLK  in  1  system clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- wr_en  in  1  push wr_data this cycle.
- wr_data  in  DATA_BITS  byte to enqueue.
- flush  in  1  discard all queued entries.
- enable  in  1  allow new launches; in-flight frame always completes.
- err_clr  in  1  clear sticky overflow and tx_err.
- tx_busy  in  1  from transmitter.
- tx_done  in  1  from transmitter, 1-cycle end-of-frame pulse.
- tx_en  out  1  registered 1-cycle launch pulse to transmitter.
- tx_data  out  DATA_BITS  registered byte; held stable from the launch cycle until the next launch.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: write attempted while full.
- tx_err  out  1  sticky: timeout waiting for tx_done.
- ctrl_busy  out  1  1 while a frame is launched and not yet completed.

Behaviour:
- Reset (async, immediate): tx_en=0, tx_data=0, full=0, empty=1, count=0, overflow=0, tx_err=0, ctrl_busy=0, pointers=0, state=IDLE, timeout counter=0.
- Storage: DEPTH x DATA_BITS array. Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. full, empty and count are registered and derived from the count register.
- Write: accepted when wr_en=1, full=0 (value sampled at cycle start), flush=0. Stores at wr_ptr, wr_ptr+1.
  - wr_en=1 while full=1: data dropped, overflow<=1. This holds even if a pop occurs in the same cycle.
- Pop: happens only on a launch (below); reads mem[rd_ptr], rd_ptr+1.
- Simultaneous write and pop: count unchanged, both pointers advance.
  - Write into an empty FIFO is never popped in the same cycle; the earliest launch is the next cycle.
- Flush: rd_ptr and wr_ptr set to 0, count=0 on next edge.
  - A same-cycle write is dropped without setting overflow; a same-cycle launch is suppressed.
  - Does not affect tx_data or an in-flight frame.
- err_clr: clears overflow and tx_err. A same-cycle set event wins; the flag stays 1.
- State machine, 2 states:
  - IDLE: if enable=1, empty=0, tx_busy=0, flush=0, then on the edge: tx_data<=mem[rd_ptr], tx_en<=1, rd_ptr+1, count-1, timeout counter<=0, ctrl_busy<=1, state<=WAIT_DONE.
  - WAIT_DONE:
    - tx_en<=0, so the pulse is exactly 1 cycle.
    - Timeout counter increments every cycle.
    - tx_done=1: state<=IDLE, ctrl_busy<=0.
    - Counter reaches TIMEOUT_CYCLES-1 without tx_done: tx_err<=1, state<=IDLE, ctrl_busy<=0. The byte is considered lost and is not re-queued.
- tx_busy is ignored in WAIT_DONE, because it lags the transmitter's internal state by one cycle; only tx_done ends the wait.
- Back-to-back throughput: the next tx_en rises 2 cycles after the tx_done pulse (the IDLE evaluation cycle plus the registered launch).
- enable low in WAIT_DONE: the frame completes normally; no further launch occurs until enable=1.
- Reset mid-frame: the controller returns to IDLE with the FIFO emptied. The transmitter shares PRESETn, so no stale tx_done is expected.

Test Plan:
- Reset, then write 0x55 with enable=1 -> tx_en high for exactly 1 cycle with tx_data=0x55; count 1->0; ctrl_busy=1 until the cycle after tx_done.
- Write 0x55, 0x99, 0xA3 back-to-back with enable=1, transmitter CLKS_PER_BIT=4 -> serial line carries the three frames in order; each tx_en occurs 2 cycles after the previous tx_done.
- DEPTH=4, enable=0, write 5 bytes -> full=1 after the 4th, overflow=1 on the 5th, count=4. Then pulse err_clr -> overflow=0. Then enable=1 -> the first 4 bytes are sent in order.
- Queue 3 bytes, enable=1; during the first frame pulse flush together with wr_en (0x11) -> the in-flight frame completes, count=0, 0x11 is not stored, overflow stays 0, no further tx_en.
- Hold tx_done=0 (stubbed transmitter), TIMEOUT_CYCLES=64, one byte queued -> tx_err=1 exactly 64 cycles after tx_en; state returns to IDLE and the next queued byte launches.
- Assert PRESETn low while in WAIT_DONE with 2 bytes queued -> all outputs take their reset values immediately; after release, empty=1 and no tx_en is issued.
